// File: rtl/joseproc_oci_pkg.sv
// Shared types and width helpers for the JoseProc OCI trace path.
package joseproc_oci_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } dct_state_e;

  localparam int DCT_FRAME_W_DEF = 2;
  localparam int DCT_FRAMES_DEF  = 15;

  // Bits needed to hold any value in 0..max_val.
  function automatic int dct_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/joseproc_oci_dct_fifo.sv
// First-word-fall-through word queue; head data reads as zero while empty.
module joseproc_oci_dct_fifo
  import joseproc_oci_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic [dct_width(DEPTH)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = dct_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop_i && (level_q != '0);
  // A pop at the same edge frees the slot being written when full.
  assign push_ok = push_i && ((level_q != LVL_W'(DEPTH)) || pop_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_data_o = (level_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign level_o   = level_q;

endmodule

// File: rtl/joseproc_oci_dct_packer.sv
// Packs trace frames into words, queues them, and handles the end-of-test flush/drain.
module joseproc_oci_dct_packer
  import joseproc_oci_pkg::*;
#(
  parameter int FRAME_W    = DCT_FRAME_W_DEF,
  parameter int FRAMES     = DCT_FRAMES_DEF,
  parameter int FIFO_DEPTH = 4,
  localparam int WORD_W    = FRAME_W * FRAMES,
  localparam int CNT_W     = dct_width(FRAMES),
  localparam int LVL_W     = dct_width(FIFO_DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               test_ending,
  output logic [WORD_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]   dct_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic               test_has_ended
);

  dct_state_e        state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d, merged_buf;
  logic [CNT_W-1:0]  cnt_q, cnt_d, merged_cnt;
  logic              ovf_q, ovf_d, ended_q, ended_d;
  logic              frame_acc, word_done, flush, push_req, push_ok, pop;
  logic [CNT_W+WORD_W-1:0] fifo_rd;

  assign frame_acc  = (state_q == RUN) && frame_valid;
  assign flush      = (state_q == RUN) && test_ending;
  assign merged_cnt = cnt_q + CNT_W'(frame_acc);
  assign word_done  = frame_acc && (cnt_q == CNT_W'(FRAMES - 1));

  always_comb begin
    merged_buf = buf_q;
    if (frame_acc) merged_buf[cnt_q*FRAME_W +: FRAME_W] = frame_data;
  end

  // A flush that coincides with word completion pushes only the full word.
  assign push_req = word_done || (flush && (merged_cnt != '0));
  assign pop      = out_valid && out_ready;
  assign push_ok  = push_req && ((fifo_level != LVL_W'(FIFO_DEPTH)) || pop);

  joseproc_oci_dct_fifo #(
    .WIDTH (CNT_W + WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push_ok),
    .push_data_i ({merged_cnt, merged_buf}),
    .pop_i       (pop),
    .rd_data_o   (fifo_rd),
    .level_o     (fifo_level)
  );

  assign {out_count, out_data} = fifo_rd;
  assign out_valid             = (fifo_level != '0);

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ended_d = ended_q;
    case (state_q)
      RUN: begin
        buf_d = merged_buf;
        cnt_d = merged_cnt;
        if (word_done || test_ending) begin
          buf_d = '0;
          cnt_d = '0;
        end
        if (test_ending) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_level == '0) begin
          state_d = ENDED;
          ended_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (push_req && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ended_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ended_q <= ended_d;
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign overflow       = ovf_q;
  assign test_has_ended = ended_q;

endmodule

// File: tb/tb_joseproc_oci_dct_packer.sv
// Bench for the DCT packer: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_joseproc_oci_dct_packer;

  localparam int FW    = 2;
  localparam int NF    = 15;
  localparam int DEPTH = 4;
  localparam int WW    = FW * NF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic          test_ending;
  logic          out_ready;
  logic [WW-1:0] dct_buffer, out_data;
  logic [3:0]    dct_count, out_count;
  logic          out_valid, overflow, test_has_ended;
  logic [2:0]    fifo_level;

  joseproc_oci_dct_packer #(
    .FRAME_W    (FW),
    .FRAMES     (NF),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_valid    (frame_valid),
    .frame_data     (frame_data),
    .test_ending    (test_ending),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_count      (out_count),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list of pending frames, queue of finished words.
  typedef struct {
    logic [WW-1:0] data;
    int            cnt;
  } word_t;

  logic [FW-1:0] m_part[$];
  word_t         m_q[$];
  int            m_phase;   // 0 packing, 1 draining, 2 finished
  bit            m_ovf, m_ended;

  function automatic logic [WW-1:0] pack_part();
    logic [WW-1:0] w = '0;
    foreach (m_part[k]) w[k*FW +: FW] = m_part[k];
    return w;
  endfunction

  task automatic m_push();
    word_t w;
    w.data = pack_part();
    w.cnt  = m_part.size();
    if (m_q.size() < DEPTH) m_q.push_back(w);
    else m_ovf = 1'b1;
    m_part.delete();
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_part.delete();
      m_q.delete();
      m_phase = 0;
      m_ovf   = 1'b0;
      m_ended = 1'b0;
    end else begin
      bit was_empty;
      was_empty = (m_q.size() == 0);
      if (!was_empty && out_ready) void'(m_q.pop_front());
      if (m_phase == 0) begin
        if (frame_valid) m_part.push_back(frame_data);
        if (m_part.size() == NF) m_push();
        if (test_ending) begin
          if (m_part.size() > 0) m_push();
          m_phase = 1;
        end
      end else if (m_phase == 1 && was_empty) begin
        m_phase = 2;
        m_ended = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [WW-1:0] e_data;
    int e_cnt;
    e_data = (m_q.size() != 0) ? m_q[0].data : '0;
    e_cnt  = (m_q.size() != 0) ? m_q[0].cnt : 0;
    check("dct_buffer", 64'(dct_buffer), 64'(pack_part()));
    check("dct_count", 64'(dct_count), 64'(m_part.size()));
    check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check("out_data", 64'(out_data), 64'(e_data));
    check("out_count", 64'(out_count), 64'(e_cnt));
    check("fifo_level", 64'(fifo_level), 64'(m_q.size()));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("test_has_ended", 64'(test_has_ended), 64'(m_ended));
  end

  // Inputs change 2 time units after a rising edge; returns 2 units after the next one.
  task automatic cyc(input logic fv, input logic [FW-1:0] fd, input logic te, input logic rdy);
    frame_valid = fv;
    frame_data  = fd;
    test_ending = te;
    out_ready   = rdy;
    @(posedge clk);
    #2;
  endtask

  task automatic do_rst();
    reset_n = 1'b0;
    cyc(1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  task automatic frames(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, FW'($urandom_range(3, 0)), 1'b0, rdy);
  endtask

  initial begin
    logic [WW-1:0] t1_word;
    logic [15:0]   upper;
    int            popped;

    frame_valid = 1'b0;
    frame_data  = '0;
    test_ending = 1'b0;
    out_ready   = 1'b0;
    reset_n     = 1'b0;
    #3;
    do_rst();
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ended", 64'(test_has_ended), 64'd0);

    // 1) pattern 1,2,3,... ; frame 0 in the least significant bits
    t1_word = 30'b111001_111001_111001_111001_111001;
    for (int k = 0; k < NF; k++) begin
      cyc(1'b1, FW'((k % 3) + 1), 1'b0, 1'b1);
      if (k == NF - 2) check("t1_valid_early", 64'(out_valid), 64'd0);
    end
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_count", 64'(out_count), 64'd15);
    check("t1_data", 64'(out_data), 64'(t1_word));
    check("t1_dct_count", 64'(dct_count), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("t1_level_after_pop", 64'(fifo_level), 64'd0);

    // 2) overflow on the fifth word, then drain exactly four
    do_rst();
    frames(5 * NF, 1'b0);
    check("t2_level", 64'(fifo_level), 64'd4);
    check("t2_overflow", 64'(overflow), 64'd1);
    popped = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) popped++;
      cyc(1'b0, '0, 1'b0, 1'b1);
    end
    check("t2_popped", 64'(popped), 64'd4);
    check("t2_overflow_sticky", 64'(overflow), 64'd1);

    // 3) full FIFO, push and pop on the same edge
    do_rst();
    frames(4 * NF, 1'b0);
    check("t3_level_full", 64'(fifo_level), 64'd4);
    frames(NF - 1, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b1);
    check("t3_level", 64'(fifo_level), 64'd4);
    check("t3_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b0, 1'b1);

    // 4) partial flush of 7 frames
    do_rst();
    frames(7, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    upper = out_data[WW-1:WW-16];
    check("t4_count", 64'(out_count), 64'd7);
    check("t4_upper", 64'(upper), 64'd0);
    check("t4_ended_early", 64'(test_has_ended), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("t4_level", 64'(fifo_level), 64'd0);
    check("t4_ended_at_pop", 64'(test_has_ended), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("t4_ended", 64'(test_has_ended), 64'd1);

    // 5) flush in the cycle of the 15th frame
    do_rst();
    frames(NF - 1, 1'b0);
    cyc(1'b1, 2'b11, 1'b1, 1'b0);
    check("t5_level", 64'(fifo_level), 64'd1);
    check("t5_count", 64'(out_count), 64'd15);
    check("t5_dct_count", 64'(dct_count), 64'd0);
    for (int i = 0; i < 20 && !test_has_ended; i++) cyc(1'b1, 2'b01, 1'b1, 1'b1);
    check("t5_ended", 64'(test_has_ended), 64'd1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 2'b10, 1'b1, 1'b1);
    check("t5_ignored_count", 64'(dct_count), 64'd0);
    check("t5_ignored_level", 64'(fifo_level), 64'd0);

    // 6) asynchronous reset while draining
    do_rst();
    frames(3 * NF, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    check("t6_level_pre", 64'(fifo_level), 64'd3);
    reset_n = 1'b0;
    #1;
    check("t6_level", 64'(fifo_level), 64'd0);
    check("t6_valid", 64'(out_valid), 64'd0);
    check("t6_data", 64'(out_data), 64'd0);
    check("t6_count", 64'(out_count), 64'd0);
    check("t6_ended", 64'(test_has_ended), 64'd0);
    check("t6_overflow", 64'(overflow), 64'd0);
    check("t6_dct_count", 64'(dct_count), 64'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    frames(3, 1'b0);
    check("t6_run_resumed", 64'(dct_count), 64'd3);

    // Random traffic with occasional flushes and resets
    do_rst();
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_rst();
      cyc(1'($urandom_range(3, 0) != 0), FW'($urandom_range(3, 0)),
          1'($urandom_range(249, 0) == 0), 1'($urandom_range(2, 0) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
